// File: rtl/line_window_reader.sv
// line_window_reader: writes a raster pixel stream into BUFS rotating line
// stores and, once ROWS complete lines are held, reads them back column by
// column as a ROWS x ROWS window for the gradient/corner stage.
//
// state   | meaning
// IDLE    | waiting for ROWS complete lines (occupancy >= ROWS*LINE_W)
// RD_LINE | emitting windows for columns 0..LINE_W-ROWS of the oldest lines
module line_window_reader #(
    parameter int LINE_W = 512,
    parameter int ROWS   = 6,
    parameter int BUFS   = 7,
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             pixel_data,
    input  logic                          pixel_valid,
    output logic                          pixel_ready,
    output logic [ROWS*ROWS*DATA_W-1:0]   window_data,
    output logic                          window_valid,
    input  logic                          window_ready,
    output logic                          line_done
);

    localparam int PTR_W = $clog2(LINE_W);
    localparam int BUF_W = $clog2(BUFS);
    localparam int OCC_W = $clog2(BUFS*LINE_W+1);
    localparam int WIN_W = ROWS*ROWS*DATA_W;

    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(BUFS*LINE_W);
    localparam logic [OCC_W-1:0] OCC_START = OCC_W'(ROWS*LINE_W);
    localparam logic [OCC_W-1:0] OCC_LINE  = OCC_W'(LINE_W);
    localparam logic [PTR_W-1:0] LAST_COL  = PTR_W'(LINE_W-ROWS);
    localparam logic [PTR_W-1:0] DONE_COL  = PTR_W'(LINE_W-ROWS+1);
    localparam logic [BUF_W-1:0] BUF_LAST  = BUF_W'(BUFS-1);
    localparam logic [BUF_W:0]   BUF_MOD   = (BUF_W+1)'(BUFS);

    typedef enum logic {IDLE, RD_LINE} state_t;

    logic [DATA_W-1:0] store_q [BUFS][LINE_W];

    state_t            state_q;
    logic [BUF_W-1:0]  wr_buf_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [BUF_W-1:0]  rd_base_q;
    logic [PTR_W-1:0]  rd_col_q;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [WIN_W-1:0]  window_q, window_d;
    logic              window_valid_q;
    logic              line_done_q;

    logic              push;
    logic              adv;
    logic              line_pop;
    logic [BUF_W:0]    bsum;
    logic [PTR_W-1:0]  addr;

    // Occupancy never exceeds BUFS lines, so the ROWS stores being read are
    // never the store being written.
    assign pixel_ready  = occ_q < OCC_FULL;
    assign push         = pixel_valid & pixel_ready;
    assign adv          = ~window_valid_q | window_ready;
    // Window for column LINE_W-ROWS is on the output and being taken now.
    assign line_pop     = (state_q == RD_LINE) & window_valid_q & window_ready
                          & (rd_col_q == DONE_COL);

    assign window_data  = window_q;
    assign window_valid = window_valid_q;
    assign line_done    = line_done_q;

    // Line store write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (push) begin
            store_q[wr_buf_q][wr_ptr_q] <= pixel_data;
        end
    end

    // Occupancy: +1 per accepted pixel, -LINE_W per completed line read.
    always_comb begin
        occ_d = occ_q;
        if (push) begin
            occ_d = occ_d + OCC_W'(1);
        end
        if (line_pop) begin
            occ_d = occ_d - OCC_LINE;
        end
    end

    // Write pointer, write store rotation and occupancy register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_buf_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            occ_q <= occ_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (wr_ptr_q == {PTR_W{1'b1}}) begin
                    wr_buf_q <= (wr_buf_q == BUF_LAST) ? '0 : wr_buf_q + BUF_W'(1);
                end
            end
        end
    end

    // Gather the ROWS x ROWS window at rd_col from stores rd_base.. (mod BUFS).
    always_comb begin
        window_d = '0;
        bsum     = '0;
        addr     = '0;
        for (int r = 0; r < ROWS; r++) begin
            bsum = {1'b0, rd_base_q} + (BUF_W+1)'(r);
            if (bsum >= BUF_MOD) begin
                bsum = bsum - BUF_MOD;
            end
            for (int c = 0; c < ROWS; c++) begin
                addr = rd_col_q + PTR_W'(c);
                window_d[(r*ROWS+c)*DATA_W +: DATA_W] = store_q[bsum[BUF_W-1:0]][addr];
            end
        end
    end

    // Read FSM with registered window, valid and line_done outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            rd_base_q      <= '0;
            rd_col_q       <= '0;
            window_q       <= '0;
            window_valid_q <= 1'b0;
            line_done_q    <= 1'b0;
        end else begin
            line_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (occ_q >= OCC_START) begin
                        state_q  <= RD_LINE;
                        rd_col_q <= '0;
                    end
                end
                RD_LINE: begin
                    if (adv) begin
                        if (rd_col_q <= LAST_COL) begin
                            window_q       <= window_d;
                            window_valid_q <= 1'b1;
                            rd_col_q       <= rd_col_q + PTR_W'(1);
                        end else begin
                            window_valid_q <= 1'b0;
                            if (line_pop) begin
                                line_done_q <= 1'b1;
                                rd_base_q   <= (rd_base_q == BUF_LAST) ? '0 : rd_base_q + BUF_W'(1);
                                rd_col_q    <= '0;
                                state_q     <= IDLE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_window_reader.sv
// Directed bench for line_window_reader with LINE_W=16, ROWS=6, BUFS=7.
// Pixel k after reset carries (k + off) mod 256; window n after reset is
// line n/11, column n%11.
module tb_line_window_reader;

    localparam int LW = 16;
    localparam int RW = 6;
    localparam int BF = 7;
    localparam int DW = 8;
    localparam int WW = RW*RW*DW;
    localparam int WPL = LW - RW + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] pixel_data;
    logic          pixel_valid;
    logic          pixel_ready;
    logic [WW-1:0] window_data;
    logic          window_valid;
    logic          window_ready;
    logic          line_done;

    int            checks = 0;
    int            errors = 0;
    int            sent;
    logic [7:0]    off;
    logic [WW-1:0] win_q[$];
    int            ld_at[$];
    int            ld_cnt;
    int            first_valid_sent;
    int            ready_low_cnt;

    line_window_reader #(.LINE_W(LW), .ROWS(RW), .BUFS(BF), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .window_data  (window_data),
        .window_valid (window_valid),
        .window_ready (window_ready),
        .line_done    (line_done)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge: record windows that the next edge accepts.
    always @(negedge clk) begin
        if (reset) begin
            if (window_valid && first_valid_sent < 0) first_valid_sent <= sent;
            if (window_valid && window_ready) win_q.push_back(window_data);
            if (line_done) begin
                ld_cnt <= ld_cnt + 1;
                ld_at.push_back(win_q.size());
            end
            if (!pixel_ready) ready_low_cnt <= ready_low_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] exp_win(input int n, input logic [7:0] o);
        logic [WW-1:0] w;
        int L, c;
        L = n / WPL;
        c = n % WPL;
        w = '0;
        for (int r = 0; r < RW; r++)
            for (int j = 0; j < RW; j++)
                w[(r*RW+j)*DW +: DW] = 8'((L+r)*LW + c + j) + o;
        return w;
    endfunction

    function automatic int win_px(input int n, input int r, input int c);
        logic [WW-1:0] w;
        if (n >= win_q.size()) return -1;
        w = win_q[n];
        return int'(w[(r*RW+c)*DW +: DW]);
    endfunction

    task automatic check_windows(input string tag, input int n_exp);
        int bad;
        bad = -1;
        for (int i = 0; i < win_q.size(); i++)
            if (bad < 0 && win_q[i] !== exp_win(i, off)) bad = i;
        chk({tag, "_window_count"}, win_q.size(), n_exp);
        chk({tag, "_first_bad_window"}, bad, -1);
    endtask

    // One clock of stimulus; pixel_data is garbage whenever it cannot be taken.
    task automatic step(input bit pv, input bit wr);
        bit acc;
        pixel_valid  = pv;
        window_ready = wr;
        pixel_data   = pixel_ready ? (8'(sent) + off) : 8'hEE;
        acc          = pv && pixel_ready;
        @(posedge clk);
        #1;
        if (acc) sent++;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        pixel_valid  = 1'b0;
        window_ready = 1'b0;
        #1;
        win_q.delete();
        ld_at.delete();
        ld_cnt           = 0;
        first_valid_sent = -1;
        ready_low_cnt    = 0;
        sent             = 0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; pixel_valid = 1'b0; window_ready = 1'b0; pixel_data = '0;
        off = 8'h00; sent = 0; ld_cnt = 0; first_valid_sent = -1; ready_low_cnt = 0;
        @(posedge clk);
        #2;
        chk("rst_window_valid", window_valid, 0);
        chk("rst_pixel_ready", pixel_ready, 1);
        chk("rst_line_done", line_done, 0);
        chk_w("rst_window_data", window_data, '0);

        // A: continuous stream, 14 lines, downstream always ready
        do_reset();
        for (int i = 0; i < 224; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 80; i++) step(1'b0, 1'b1);
        chk("A_ready_low_cycles", ready_low_cnt, 0);
        chk("A_first_valid_after_pixels", first_valid_sent, 98);
        chk("A_line_done_count", ld_cnt, 9);
        chk("A_windows_at_first_line_done", ld_at.size() > 0 ? ld_at[0] : -1, 11);
        chk("A_first_win_r5c3", win_px(0, 5, 3), 83);
        chk("A_line1_row0", win_px(11, 0, 0), 16);
        chk("A_line7_row0_wrap", win_px(77, 0, 0), 112);
        check_windows("A", 99);

        // B: downstream stalled, block fills, then released
        do_reset();
        for (int i = 0; i < 200 && pixel_ready; i++) step(1'b1, 1'b0);
        chk("B_first_valid_after_pixels", first_valid_sent, 98);
        chk("B_pixels_at_full", sent, 112);
        chk("B_pixel_ready_full", pixel_ready, 0);
        chk_w("B_window_col0", window_data, exp_win(0, off));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        chk_w("B_window_col0_frozen", window_data, exp_win(0, off));
        chk("B_valid_held", window_valid, 1);
        chk("B_ready_still_low", pixel_ready, 0);
        for (int i = 0; i < 40 && !line_done; i++) step(1'b1, 1'b1);
        chk("B_line_done_seen", line_done, 1);
        chk("B_pixel_ready_after_last", pixel_ready, 1);
        chk("B_pixels_until_last", sent, 112);
        chk("B_windows_line0", win_q.size(), 11);
        for (int i = 0; i < 48; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 80; i++) step(1'b0, 1'b1);
        chk("B_line_done_count", ld_cnt, 5);
        chk("B_col1_after_release", win_px(1, 0, 0), 1);
        check_windows("B", 55);

        // C: toggling window_ready, random pixel gaps, 20 lines
        do_reset();
        for (int i = 0; i < 4000 && ld_cnt < 15; i++)
            step(sent < 320 ? 1'($urandom_range(0, 1)) : 1'b0, 1'(i % 2));
        for (int i = 0; i < 40; i++) step(1'b0, 1'(i % 2));
        chk("C_pixels_sent", sent, 320);
        chk("C_line_done_count", ld_cnt, 15);
        check_windows("C", 165);

        // D: async reset mid-line at column 5 of line 3, then a new stream
        do_reset();
        for (int i = 0; i < 600 && win_q.size() < 38; i++) step(1'b1, 1'b1);
        chk("D_reached_col5_line3", win_q.size(), 38);
        chk("D_valid_before_reset", window_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("D_rst_window_valid", window_valid, 0);
        chk("D_rst_pixel_ready", pixel_ready, 1);
        chk("D_rst_line_done", line_done, 0);
        chk_w("D_rst_window_data", window_data, '0);
        off = 8'h55;
        do_reset();
        for (int i = 0; i < 150; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 80; i++) step(1'b0, 1'b1);
        chk("D_first_valid_after_pixels", first_valid_sent, 98);
        chk("D_first_win_r0c0", win_px(0, 0, 0), 8'h55);
        chk("D_line_done_count", ld_cnt, 4);
        check_windows("D", 44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
